// File: rtl/coeff_loader_pkg.sv
// Shared constants and types for the coefficient loader.
//   CL_D_WIDTH : coefficient width in bits
//   CL_DEGREE  : polynomial degree (coefficients per polynomial)
//   CL_BN      : number of memory banks (one coefficient per bank per row)
//   CL_MA      : rows per bank
//   state_t    : loader FSM states
package coeff_loader_pkg;

    localparam int CL_D_WIDTH = 18;
    localparam int CL_DEGREE  = 256;
    localparam int CL_BN      = 16;
    localparam int CL_MA      = CL_DEGREE / CL_BN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/coeff_loader_if.sv
// Bus bundle between a coefficient source and the loader.
//   master : drives modulus/start/in_valid/in_data, observes the rest
//   slave  : the loader side (in_ready, memory write port, status flags)
interface coeff_loader_if
    import coeff_loader_pkg::*;
#(
    parameter int D_width = CL_D_WIDTH,
    parameter int BN      = CL_BN,
    parameter int AW      = $clog2(CL_MA)
) ();

    logic [D_width-1:0]    modulus;
    logic                  start;
    logic                  in_valid;
    logic [D_width-1:0]    in_data;
    logic                  in_ready;
    logic                  mem_wr_en;
    logic [AW-1:0]         mem_wr_addr;
    logic [BN*D_width-1:0] mem_wr_data;
    logic                  busy;
    logic                  done;
    logic                  range_err;

    modport master (
        output modulus, start, in_valid, in_data,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, range_err
    );

    modport slave (
        input  modulus, start, in_valid, in_data,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, range_err
    );

endinterface

// File: rtl/coeff_loader_mod_reduce.sv
// Single conditional subtraction modulo `modulus`.
//   c       : input coefficient
//   modulus : NTT modulus
//   r       : c - modulus when c >= modulus, else c
//   over    : c >= 2*modulus (one subtraction is not enough)
// Comparisons are done one bit wider so 2*modulus cannot overflow.
module mod_reduce #(
    parameter int D_width = 18
) (
    input  logic [D_width-1:0] c,
    input  logic [D_width-1:0] modulus,
    output logic [D_width-1:0] r,
    output logic               over
);

    logic [D_width:0] c_ext;
    logic [D_width:0] m_ext;
    logic [D_width:0] m2_ext;
    logic             ge;

    assign c_ext  = {1'b0, c};
    assign m_ext  = {1'b0, modulus};
    assign m2_ext = {modulus, 1'b0};
    assign ge     = (c_ext >= m_ext);
    assign over   = (c_ext >= m2_ext);
    assign r      = ge ? (c - modulus) : c;

endmodule

// File: rtl/coeff_loader.sv
// Streams one polynomial into BN parallel banks, one row per BN coefficients.
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : coeff_loader_if.slave -- start/in_valid/in_data/modulus in;
//          in_ready, row write port (mem_wr_*), busy, done, range_err out
// Coefficient i lands in bank i%BN of row i/BN. The first BN-1 coefficients
// of a row are buffered; the row is written on the edge that accepts the
// last one, so input runs at one coefficient per cycle with no stall.
module coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int D_width = CL_D_WIDTH,
    parameter int BN      = CL_BN,
    parameter int MA      = CL_DEGREE / CL_BN
) (
    input  logic          clk,
    input  logic          rst,
    coeff_loader_if.slave bus
);

    localparam int AW = (MA > 1) ? $clog2(MA) : 1;
    localparam int SW = (BN > 1) ? $clog2(BN) : 1;

    state_t state_reg, state_next;

    logic [SW-1:0]         slot_reg;
    logic [AW-1:0]         row_reg;
    logic                  range_err_reg;
    logic                  wr_en_reg;
    logic [AW-1:0]         wr_addr_reg;
    logic [BN*D_width-1:0] wr_data_reg;
    logic [D_width-1:0]    buf_reg [BN-1];

    logic [D_width-1:0]    reduced;
    logic                  over;
    logic [BN*D_width-1:0] row_data;
    logic                  accept;
    logic                  start_ok;
    logic                  last_slot;
    logic                  last_row;

    mod_reduce #(.D_width(D_width)) u_reduce (
        .c       (bus.in_data),
        .modulus (bus.modulus),
        .r       (reduced),
        .over    (over)
    );

    assign accept    = (state_reg == LOAD) && bus.in_valid;
    assign start_ok  = (state_reg == IDLE) && bus.start;
    assign last_slot = (slot_reg == SW'(BN - 1));
    assign last_row  = (row_reg == AW'(MA - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (accept && last_slot && last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row buffer: slots 0..BN-2 hold the partial row; the final slot goes
    // straight from the reducer into the write word.
    genvar gi;
    generate
        for (gi = 0; gi < BN - 1; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!rst) begin
                    buf_reg[gi] <= '0;
                end else if (accept && (slot_reg == SW'(gi))) begin
                    buf_reg[gi] <= reduced;
                end
            end
            assign row_data[gi*D_width +: D_width] = buf_reg[gi];
        end
    endgenerate
    assign row_data[(BN-1)*D_width +: D_width] = reduced;

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_reg      <= '0;
            row_reg       <= '0;
            range_err_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            if (start_ok) begin
                slot_reg      <= '0;
                row_reg       <= '0;
                range_err_reg <= 1'b0;
            end else if (accept) begin
                range_err_reg <= range_err_reg | over;
                if (last_slot) begin
                    slot_reg    <= '0;
                    row_reg     <= last_row ? '0 : row_reg + AW'(1);
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= row_reg;
                    wr_data_reg <= row_data;
                end else begin
                    slot_reg <= slot_reg + SW'(1);
                end
            end
        end
    end

    assign bus.in_ready    = (state_reg == LOAD);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.range_err   = range_err_reg;
    assign bus.mem_wr_en   = wr_en_reg;
    assign bus.mem_wr_addr = wr_addr_reg;
    assign bus.mem_wr_data = wr_data_reg;

endmodule

// File: tb/tb_coeff_loader.sv
module tb_coeff_loader;
    import coeff_loader_pkg::*;

    localparam int D  = CL_D_WIDTH;
    localparam int BN = CL_BN;
    localparam int MA = CL_MA;
    localparam int N  = BN * MA;
    localparam int W  = BN * D;
    localparam int M  = 65537;

    logic clk = 1'b0;
    logic rst = 1'b0;

    coeff_loader_if bus ();

    coeff_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int coeff [N];

    logic [W-1:0] log_data [$];
    int           log_addr [$];
    logic         log_done [$];
    int           log_cyc  [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            log_data.push_back(bus.mem_wr_data);
            log_addr.push_back(int'(bus.mem_wr_addr));
            log_done.push_back(bus.done);
            log_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int first, input int count, input bit gap);
        for (int i = first; i < first + count; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = D'(coeff[i]);
            step();
            if (gap) begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
                step();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_addr.delete();
        log_done.delete();
        log_cyc.delete();
        done_cnt = 0;
    endtask

    function automatic int red(input int c);
        return (c >= M) ? c - M : c;
    endfunction

    task automatic check_rows(input string tag, input int spacing);
        logic [W-1:0] e;
        check($sformatf("%s_nwrites", tag), W'(log_addr.size()), W'(MA));
        check($sformatf("%s_done_pulses", tag), W'(done_cnt), W'(1));
        for (int k = 0; k < log_addr.size() && k < MA; k++) begin
            e = '0;
            for (int b = 0; b < BN; b++) e[b*D +: D] = D'(red(coeff[k*BN + b]));
            check($sformatf("%s_addr%0d", tag, k), W'(log_addr[k]), W'(k));
            check($sformatf("%s_data%0d", tag, k), log_data[k], e);
            check($sformatf("%s_done%0d", tag, k), W'(log_done[k]), W'(k == MA - 1));
            if (k > 0)
                check($sformatf("%s_gap%0d", tag, k), W'(log_cyc[k] - log_cyc[k-1]), W'(spacing));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},  W'(bus.in_ready),    W'(0));
        check({tag, "_wr_en"},     W'(bus.mem_wr_en),   W'(0));
        check({tag, "_wr_addr"},   W'(bus.mem_wr_addr), W'(0));
        check({tag, "_wr_data"},   bus.mem_wr_data,     W'(0));
        check({tag, "_busy"},      W'(bus.busy),        W'(0));
        check({tag, "_done"},      W'(bus.done),        W'(0));
        check({tag, "_range_err"}, W'(bus.range_err),   W'(0));
    endtask

    initial begin
        bus.modulus  = D'(M);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        step();
        step();
        check_idle_zero("reset");
        rst = 1'b1;
        step();

        // Sequential data, continuous valid: bank b of row k holds 16k+b.
        for (int i = 0; i < N; i++) coeff[i] = i;
        clear_log();
        pulse_start();
        check("seq_busy", W'(bus.busy), W'(1));
        check("seq_in_ready", W'(bus.in_ready), W'(1));
        feed(0, N, 1'b0);
        step();
        step();
        check_rows("seq", 16);
        if (log_data.size() > 1)
            check("seq_row1_bank5", W'(log_data[1][5*D +: D]), W'(21));
        check("seq_busy_after", W'(bus.busy), W'(0));
        check("seq_range_err", W'(bus.range_err), W'(0));

        // in_valid toggling: same rows, writes 32 cycles apart.
        clear_log();
        pulse_start();
        feed(0, N, 1'b1);
        step();
        step();
        check_rows("tog", 32);

        // Reduction values below 2*modulus.
        coeff[0] = 65537;
        coeff[1] = 70000;
        coeff[2] = 65536;
        clear_log();
        pulse_start();
        feed(0, N, 1'b0);
        step();
        step();
        check_rows("red", 16);
        if (log_data.size() > 0) begin
            check("red_65537", W'(log_data[0][0*D +: D]), W'(0));
            check("red_70000", W'(log_data[0][1*D +: D]), W'(4463));
            check("red_65536", W'(log_data[0][2*D +: D]), W'(65536));
        end
        check("red_range_err", W'(bus.range_err), W'(0));

        // Out-of-range value plus a start pulse in the middle of LOAD.
        for (int i = 0; i < N; i++) coeff[i] = i;
        coeff[3] = 131074;
        clear_log();
        pulse_start();
        feed(0, 8, 1'b0);
        check("rng_err_set", W'(bus.range_err), W'(1));
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = D'(coeff[8]);
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_start_range_err", W'(bus.range_err), W'(1));
        check("mid_start_busy", W'(bus.busy), W'(1));
        feed(9, N - 9, 1'b0);
        step();
        step();
        check_rows("mid", 16);
        if (log_data.size() > 0)
            check("rng_131074", W'(log_data[0][3*D +: D]), W'(65537));
        check("rng_err_sticky", W'(bus.range_err), W'(1));
        pulse_start();
        check("rng_err_cleared", W'(bus.range_err), W'(0));

        // Reset after 20 coefficients: row 0 written, row 1 never.
        for (int i = 0; i < N; i++) coeff[i] = i;
        coeff[5] = 200000;
        clear_log();
        feed(0, 20, 1'b0);
        check("rst_pre_range_err", W'(bus.range_err), W'(1));
        check("rst_pre_nwrites", W'(log_addr.size()), W'(1));
        rst = 1'b0;
        step();
        check_idle_zero("midrst");
        rst = 1'b1;
        step();
        step();
        step();
        check("rst_post_nwrites", W'(log_addr.size()), W'(1));

        // Fresh load after reset starts from row 0.
        coeff[5] = 5;
        clear_log();
        pulse_start();
        feed(0, N, 1'b0);
        step();
        step();
        check_rows("reload", 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL have parameter D_width, default `D_width, meaning coefficient width in bits.
REQ-002 SHALL have parameter BN, default 16, meaning number of memory banks (one coefficient per bank per row).
REQ-003 SHALL have parameter MA, default `degree/BN, meaning rows per bank; address width AW = $clog2(MA).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port modulus  input  D_width  NTT modulus (e.g. 65537), stable while busy.
REQ-007 SHALL have port start  input  1  one-cycle request to begin loading one polynomial.
REQ-008 SHALL have port in_valid  input  1  in_data holds a coefficient.
REQ-009 SHALL have port in_data  input  D_width  coefficient, natural order, index 0 first.
REQ-010 SHALL have port in_ready  output  1  coefficient accepted when in_valid && in_ready.
REQ-011 SHALL have port mem_wr_en  output  1  one-row write strobe to all BN banks.
REQ-012 SHALL have port mem_wr_addr  output  AW  row address.
REQ-013 SHALL have port mem_wr_data  output  BN*D_width  bank b at bits [b*D_width +: D_width].
REQ-014 SHALL have port busy  output  1  high in LOAD and DONE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after final row written.
REQ-016 SHALL have port range_err  output  1  sticky input-out-of-range flag.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD on start; LOAD -> DONE on acceptance of coefficient BN*MA-1; DONE -> IDLE unconditionally.
REQ-018 SHALL drive in_ready = 1 only in LOAD; in_valid outside LOAD has no effect.
REQ-019 SHALL ignore start while in LOAD or DONE.
REQ-020 SHALL place accepted coefficient i in bank i%BN, row i/BN, via a slot counter (0..BN-1, wraps) and row counter (0..MA-1).
REQ-021 SHALL, on the edge accepting slot BN-1, register mem_wr_en=1, mem_wr_addr=row, mem_wr_data={new coeff, buffered slots BN-2..0}; strobe high exactly one cycle, no stall (full throughput, one coefficient per cycle).
REQ-022 SHALL reduce each coefficient before buffering: c' = (c >= modulus) ? c - modulus : c, compare in D_width+1 bits.
REQ-023 SHALL set range_err when c >= 2*modulus (write c - modulus anyway); range_err clears only on accepted start or reset.
REQ-024 SHALL assert done for one cycle in DONE, coincident with the final row's mem_wr_en (latency: last accept at edge t -> write and done visible after edge t, one cycle).
REQ-025 SHALL clear slot and row counters on accepted start; a new load always begins at row 0, bank 0.
REQ-026 SHALL drive mem_wr_en=0 in all cycles other than row completion.

Reset
REQ-027 SHALL, when rst=0 at a clock edge, force state IDLE and in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, range_err, counters, row buffer all to 0.
REQ-028 SHALL discard any partial row on reset mid-LOAD; no write is issued for it.

Structure
REQ-029 SHALL take BN, MA, degree, D_width from the shared define/package, plus a shared state enum typedef (IDLE, LOAD, DONE).
REQ-030 SHALL instantiate one sub-module mod_reduce (conditional subtraction plus overflow flag); everything else in coeff_loader.

Verification
REQ-031 SHALL test: modulus 65537, in_valid held high, in_data=i for i=0..BN*MA-1 -> row k written with bank b = 16k+b, one write every 16 cycles, done coincident with row MA-1 write.
REQ-032 SHALL test: in_data 65537 -> 0; 70000 -> 4463; 65536 -> 65536; range_err stays 0.
REQ-033 SHALL test: in_data 131074 -> written 65537, range_err=1 until next start.
REQ-034 SHALL test: in_valid toggling every other cycle -> identical row contents and addresses, writes spaced 32 cycles.
REQ-035 SHALL test: rst=0 after 20 coefficients -> all outputs 0, no write for row 1; new start reloads from row 0 correctly.
REQ-036 SHALL test: start pulsed mid-LOAD -> ignored, counters and range_err unchanged.
